// File: rtl/conv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : conv_pkg                                                     |
// | Description : Shared constants and types for the 3x3 convolution B-bus     |
// |               sequencer: B-bus mux select codes, tap count and the         |
// |               sequencer state encoding.                                    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package conv_pkg;

    // Number of kernel taps in a 3x3 neighbourhood, and the counter width
    // needed to index them.
    localparam int NUM_TAPS = 9;
    localparam int TAP_W    = 4;

    // B-bus mux select codes understood by the datapath.
    localparam logic [4:0] BSEL_MDR  = 5'd0;
    localparam logic [4:0] BSEL_K0   = 5'd1;
    localparam logic [4:0] BSEL_K1   = 5'd2;
    localparam logic [4:0] BSEL_K2   = 5'd3;
    localparam logic [4:0] BSEL_K3   = 5'd4;
    localparam logic [4:0] BSEL_K4   = 5'd5;
    localparam logic [4:0] BSEL_K5   = 5'd6;
    localparam logic [4:0] BSEL_K6   = 5'd7;
    localparam logic [4:0] BSEL_K7   = 5'd8;
    localparam logic [4:0] BSEL_K8   = 5'd9;
    localparam logic [4:0] BSEL_P1   = 5'd10;
    localparam logic [4:0] BSEL_P2   = 5'd11;
    localparam logic [4:0] BSEL_P3   = 5'd12;
    localparam logic [4:0] BSEL_DP   = 5'd13;
    localparam logic [4:0] BSEL_CV   = 5'd14;
    localparam logic [4:0] BSEL_I    = 5'd15;
    localparam logic [4:0] BSEL_MBRU = 5'd16;

    // Sequencer states, explicitly encoded.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_FETCH = 3'd2,
        ST_MAC   = 3'd3,
        ST_WB    = 3'd4,
        ST_DONE  = 3'd5
    } conv_state_e;

endpackage
`default_nettype wire

// File: rtl/conv_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : conv_addr_gen                                                |
// | Description : Neighbourhood address generator. Walks the 3x3 window in     |
// |               row-major order, keeping the current row base, column and    |
// |               tap index.                                                   |
// |   i_load      - capture base address / row pitch, restart at tap 0         |
// |   i_advance   - step to the next tap (column, wrapping to the next row)    |
// |   o_addr      - read address of the current tap (row_base + col)           |
// |   o_tap       - current tap index 0..8                                     |
// |   o_last_tap  - current tap is the final one                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_advance,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W-1:0] i_img_width,
    output logic [ADDR_W-1:0] o_addr,
    output logic [TAP_W-1:0]  o_tap,
    output logic              o_last_tap
);

    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] r_width;
    logic [1:0]        r_col;
    logic [TAP_W-1:0]  r_tap;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_base <= '0;
            r_width    <= '0;
            r_col      <= 2'd0;
            r_tap      <= '0;
        end else if (i_load) begin
            r_row_base <= i_base_addr;
            r_width    <= i_img_width;
            r_col      <= 2'd0;
            r_tap      <= '0;
        end else if (i_advance) begin
            r_tap <= r_tap + TAP_W'(1);
            if (r_col == 2'd2) begin
                // End of a window row: move down one image row (wraps naturally).
                r_col      <= 2'd0;
                r_row_base <= r_row_base + r_width;
            end else begin
                r_col <= r_col + 2'd1;
            end
        end
    end

    assign o_addr     = r_row_base + ADDR_W'(r_col);
    assign o_tap      = r_tap;
    assign o_last_tap = (r_tap == TAP_W'(NUM_TAPS - 1));

endmodule
`default_nettype wire

// File: rtl/conv_bbus_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : conv_bbus_sequencer                                          |
// | Description : Sequences one 3x3 convolution output pixel on the shared B   |
// |               bus: clears CV, fetches nine neighbourhood pixels into MDR,  |
// |               steers K0..K8 onto the B bus with a MAC strobe per tap, then |
// |               writes CV back to memory.                                    |
// |   clk, rst          - clock, synchronous active-high reset                 |
// |   start, abort      - control-unit request / abandon                       |
// |   base_addr, img_width, out_addr - operands captured on accepted start     |
// |   mem_rd_req, mem_wr_req, mem_addr, mem_ack - memory port                  |
// |   mdr_ld, cv_clr, mac_en, b_sel - datapath controls                        |
// |   busy, done        - status to the control unit                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module conv_bbus_sequencer
    import conv_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] img_width,
    input  logic [ADDR_W-1:0] out_addr,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    output logic              mdr_ld,
    output logic              cv_clr,
    output logic              mac_en,
    output logic [4:0]        b_sel,
    output logic              busy,
    output logic              done
);

    conv_state_e       r_state;
    conv_state_e       w_next;
    logic [ADDR_W-1:0] r_out_addr;

    logic              w_load;
    logic              w_advance;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [TAP_W-1:0]  w_tap;
    logic              w_last_tap;

    assign w_load    = (r_state == ST_IDLE) && start;
    assign w_advance = (r_state == ST_MAC) && !w_last_tap && !abort;

    conv_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_advance   (w_advance),
        .i_base_addr (base_addr),
        .i_img_width (img_width),
        .o_addr      (w_rd_addr),
        .o_tap       (w_tap),
        .o_last_tap  (w_last_tap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_out_addr <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_out_addr <= out_addr;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:  if (start)   w_next = ST_CLR;
            ST_CLR:                w_next = ST_FETCH;
            ST_FETCH: if (mem_ack) w_next = ST_MAC;
            ST_MAC:                w_next = w_last_tap ? ST_WB : ST_FETCH;
            ST_WB:    if (mem_ack) w_next = ST_DONE;
            ST_DONE:               w_next = ST_IDLE;
            default:               w_next = ST_IDLE;
        endcase
        // Abort wins over any pending acknowledge.
        if (abort && (r_state != ST_IDLE)) begin
            w_next = ST_IDLE;
        end
    end

    // Outputs decode from the registered state and tap counter; only mdr_ld
    // looks at mem_ack so the load coincides with the returning read data.
    always_comb begin
        mem_rd_req = 1'b0;
        mem_wr_req = 1'b0;
        mem_addr   = '0;
        mdr_ld     = 1'b0;
        cv_clr     = 1'b0;
        mac_en     = 1'b0;
        b_sel      = BSEL_MDR;
        busy       = (r_state != ST_IDLE);
        done       = 1'b0;
        unique case (r_state)
            ST_CLR: begin
                cv_clr = 1'b1;
            end
            ST_FETCH: begin
                mem_rd_req = 1'b1;
                mem_addr   = w_rd_addr;
                mdr_ld     = mem_ack && !abort;
            end
            ST_MAC: begin
                mac_en = 1'b1;
                b_sel  = BSEL_K0 + {1'b0, w_tap};
            end
            ST_WB: begin
                mem_wr_req = 1'b1;
                mem_addr   = r_out_addr;
                b_sel      = BSEL_CV;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_conv_bbus_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_conv_bbus_sequencer                                       |
// | Description : Self-checking bench for conv_bbus_sequencer. A transaction-  |
// |               level model predicts every output each cycle; directed       |
// |               scenarios add literal address / latency / count checks.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_conv_bbus_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, abort, mem_ack;
    logic [15:0] base_addr, img_width, out_addr;
    logic        mem_rd_req, mem_wr_req, mdr_ld, cv_clr, mac_en, busy, done;
    logic [15:0] mem_addr;
    logic [4:0]  b_sel;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    conv_bbus_sequencer #(.ADDR_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .base_addr  (base_addr),
        .img_width  (img_width),
        .out_addr   (out_addr),
        .mem_rd_req (mem_rd_req),
        .mem_wr_req (mem_wr_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mdr_ld     (mdr_ld),
        .cv_clr     (cv_clr),
        .mac_en     (mac_en),
        .b_sel      (b_sel),
        .busy       (busy),
        .done       (done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- transaction-level model ----------------
    // An operation is a fixed list of 21 slots: 0 clear, then fetch/mac pairs
    // for taps 0..8 (slots 1..18), 19 write-back, 20 done. Memory slots hold
    // until acknowledged.
    bit          cmp_on = 1'b0;
    bit          m_active = 1'b0;
    int          m_slot = 0;
    logic [15:0] m_base, m_width, m_out;

    int          n_mdr, n_mac, n_clr, n_done, start_cyc, done_cyc;
    logic [15:0] rd_q[$];
    logic [4:0]  bsel_q[$];
    logic [15:0] wr_addr_seen;

    bit          e_clr, e_fetch, e_mac, e_wb, e_done;
    int          e_tap;
    logic [15:0] e_addr;
    logic [4:0]  e_bsel;

    function automatic logic [15:0] tap_addr(input int t);
        logic [15:0] row, col;
        row = 16'(t / 3);
        col = 16'(t % 3);
        return m_base + row * m_width + col;
    endfunction

    always @(negedge clk) begin
        if (cmp_on) begin
            e_clr   = m_active && (m_slot == 0);
            e_fetch = m_active && (m_slot >= 1) && (m_slot <= 17) && (m_slot % 2 == 1);
            e_mac   = m_active && (m_slot >= 2) && (m_slot <= 18) && (m_slot % 2 == 0);
            e_wb    = m_active && (m_slot == 19);
            e_done  = m_active && (m_slot == 20);
            e_tap   = e_fetch ? (m_slot - 1) / 2 : (m_slot - 2) / 2;
            e_addr  = e_fetch ? tap_addr(e_tap) : (e_wb ? m_out : 16'h0000);
            e_bsel  = e_mac ? 5'(e_tap + 1) : (e_wb ? 5'd14 : 5'd0);

            chk("busy",       busy,       m_active);
            chk("done",       done,       e_done);
            chk("cv_clr",     cv_clr,     e_clr);
            chk("mem_rd_req", mem_rd_req, e_fetch);
            chk("mem_wr_req", mem_wr_req, e_wb);
            chk("mem_addr",   mem_addr,   e_addr);
            chk("mac_en",     mac_en,     e_mac);
            chk("b_sel",      b_sel,      e_bsel);
            chk("mdr_ld",     mdr_ld,     e_fetch && mem_ack && !abort);

            if (mdr_ld) begin n_mdr++; rd_q.push_back(mem_addr); end
            if (mac_en) begin n_mac++; bsel_q.push_back(b_sel); end
            if (cv_clr) n_clr++;
            if (mem_wr_req && mem_ack) wr_addr_seen = mem_addr;
            if (done) begin n_done++; done_cyc = cyc; end

            // advance the model to the next cycle
            if (rst) begin
                m_active = 1'b0;
            end else if (!m_active) begin
                if (start) begin
                    m_active  = 1'b1;
                    m_slot    = 0;
                    m_base    = base_addr;
                    m_width   = img_width;
                    m_out     = out_addr;
                    start_cyc = cyc;
                end
            end else if (abort) begin
                m_active = 1'b0;
            end else if (e_fetch || e_wb) begin
                if (mem_ack) m_slot++;
            end else if (e_done) begin
                m_active = 1'b0;
            end else begin
                m_slot++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    bit ack_always = 1'b0;
    int ack_delay  = 0;
    int req_cnt    = 0;

    // One clock; then a memory responder acknowledges each request after
    // ack_delay wait cycles (or holds mem_ack high when ack_always).
    task automatic tick();
        @(posedge clk);
        #1;
        if (ack_always) begin
            mem_ack = 1'b1;
        end else if (mem_rd_req || mem_wr_req) begin
            req_cnt++;
            mem_ack = (req_cnt > ack_delay);
            if (mem_ack) req_cnt = 0;
        end else begin
            req_cnt = 0;
            mem_ack = 1'b0;
        end
    endtask

    task automatic clear_obs();
        n_mdr = 0; n_mac = 0; n_clr = 0; n_done = 0;
        start_cyc = 0; done_cyc = 0; wr_addr_seen = 16'h0000;
        rd_q.delete();
        bsel_q.delete();
    endtask

    task automatic wait_done(input int budget);
        int k  = 0;
        int d0 = n_done;
        while (n_done == d0 && k < budget) begin
            tick();
            k++;
        end
        chk("done_within_budget", (n_done != d0), 1);
    endtask

    task automatic launch(input logic [15:0] b, input logic [15:0] w, input logic [15:0] o);
        base_addr = b; img_width = w; out_addr = o;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    logic [15:0] exp_rd [9];

    task automatic chk_reads(input string tag);
        chk({tag, "_read_count"}, rd_q.size(), 9);
        for (int i = 0; i < 9; i++) begin
            if (i < rd_q.size()) chk($sformatf("%s_rd%0d", tag, i), rd_q[i], exp_rd[i]);
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; mem_ack = 1'b0;
        base_addr = 16'h0; img_width = 16'h0; out_addr = 16'h0;
        clear_obs();
        tick();
        tick();
        cmp_on = 1'b1;
        @(negedge clk);
        // reset values
        chk("rst_busy", busy, 0);
        chk("rst_bsel", b_sel, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_reqs", {mem_rd_req, mem_wr_req, mdr_ld, cv_clr, mac_en, done}, 0);
        tick();
        rst = 1'b0;
        tick();

        // 1) zero-wait run, mem_ack tied high
        ack_always = 1'b1;
        clear_obs();
        launch(16'h0100, 16'h0020, 16'h0800);
        wait_done(60);
        exp_rd = '{16'h0100, 16'h0101, 16'h0102, 16'h0120, 16'h0121,
                   16'h0122, 16'h0140, 16'h0141, 16'h0142};
        chk_reads("zw");
        chk("zw_latency", done_cyc - start_cyc, 21);
        chk("zw_wr_addr", wr_addr_seen, 16'h0800);
        chk("zw_bsel_count", bsel_q.size(), 9);
        for (int i = 0; i < 9; i++)
            if (i < bsel_q.size()) chk($sformatf("zw_bsel%0d", i), bsel_q[i], i + 1);
        ack_always = 1'b0;
        mem_ack = 1'b0;
        tick();

        // 2) three wait cycles on every request
        ack_delay = 3;
        clear_obs();
        launch(16'h0100, 16'h0020, 16'h0800);
        wait_done(150);
        chk_reads("ws");
        chk("ws_latency", done_cyc - start_cyc, 51);
        chk("ws_mdr_ld", n_mdr, 9);
        chk("ws_mac_en", n_mac, 9);
        chk("ws_cv_clr", n_clr, 1);
        tick();

        // 3) address wrap
        ack_delay = 0;
        clear_obs();
        launch(16'hFFFE, 16'h0001, 16'h1234);
        wait_done(60);
        exp_rd = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000,
                   16'h0001, 16'h0000, 16'h0001, 16'h0002};
        chk_reads("wrap");
        chk("wrap_wr_addr", wr_addr_seen, 16'h1234);
        tick();

        // 4) start held while busy, operands changed mid-run
        ack_delay = 1;
        clear_obs();
        base_addr = 16'h0200; img_width = 16'h0010; out_addr = 16'h0900;
        start = 1'b1;
        tick();
        base_addr = 16'h5555; img_width = 16'h7777; out_addr = 16'h9999;
        repeat (14) tick();
        start = 1'b0;
        wait_done(100);
        exp_rd = '{16'h0200, 16'h0201, 16'h0202, 16'h0210, 16'h0211,
                   16'h0212, 16'h0220, 16'h0221, 16'h0222};
        chk_reads("busy_start");
        chk("busy_start_wr_addr", wr_addr_seen, 16'h0900);
        repeat (3) tick();
        chk("busy_start_one_done", n_done, 1);

        // 5) abort in FETCH of tap 4 together with mem_ack
        ack_always = 1'b1;
        clear_obs();
        launch(16'h0100, 16'h0020, 16'h0800);
        begin
            int k = 0;
            while (!(mem_rd_req && mem_addr == 16'h0121) && k < 40) begin tick(); k++; end
            chk("abort_reached_tap4", (mem_rd_req && mem_addr == 16'h0121), 1);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        chk("abort_idle_next", busy, 0);
        repeat (3) tick();
        chk("abort_mdr_count", n_mdr, 4);
        chk("abort_no_done", n_done, 0);
        clear_obs();
        launch(16'h0100, 16'h0020, 16'h0800);
        wait_done(60);
        chk("after_abort_latency", done_cyc - start_cyc, 21);
        chk("after_abort_mdr", n_mdr, 9);
        ack_always = 1'b0;
        mem_ack = 1'b0;
        tick();

        // 6) reset asserted during write-back
        ack_delay = 3;
        clear_obs();
        launch(16'h0300, 16'h0040, 16'h0A00);
        begin
            int k = 0;
            while (!mem_wr_req && k < 120) begin tick(); k++; end
            chk("rst_wb_reached", mem_wr_req, 1);
        end
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_wb_busy", busy, 0);
        chk("rst_wb_outs", {mem_rd_req, mem_wr_req, mdr_ld, cv_clr, mac_en, done}, 0);
        chk("rst_wb_addr", mem_addr, 0);
        chk("rst_wb_bsel", b_sel, 0);
        rst = 1'b0;
        repeat (4) tick();
        chk("rst_wb_no_done", n_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
